// File: rtl/inst_fetch_buffer_pkg.sv
// Shared definitions for the instruction fetch buffer: default parameters,
// FSM state type and the packed layout of one buffer entry.
// Entry layout (LSB first): adel flag, instruction word, fetch PC.
package inst_fetch_buffer_pkg;

  localparam int          IFB_DEPTH_DEF    = 4;
  localparam int          IFB_AW_DEF       = 32;
  localparam int          IFB_DW_DEF       = 32;
  localparam logic [31:0] IFB_RESET_PC_DEF = 32'hBFC0_0000;

  // Field offsets inside a packed entry; the PC field starts at IFB_INSTR_LSB + DW.
  localparam int IFB_ADEL_BIT  = 0;
  localparam int IFB_INSTR_LSB = 1;

  typedef enum logic {
    IFB_RUN  = 1'b0,
    IFB_HALT = 1'b1
  } ifb_state_e;

  // Width of one packed entry {pc, instr, adel}.
  function automatic int ifb_ent_w(input int aw, input int dw);
    return aw + dw + 1;
  endfunction

endpackage

// File: rtl/inst_fetch_buffer_fifo.sv
// Synchronous FIFO holding fetched entries (the ifb FIFO).
// Flush has priority over push and pop. A push while full is ignored
// unless a pop happens in the same cycle. Storage is not reset; only the
// pointers and occupancy are, so stale words are never presented.
module inst_fetch_buffer_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 65,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; flush clears everything.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch stage: owns the fetch PC, issues single-cycle inst-SRAM
// reads and queues returned words for decode behind a valid/ready handshake.
// Optional build macro IFB_BYPASS_EN: a live response arriving while the
// buffer is empty is presented to decode in the same cycle and only written
// into the buffer if decode does not take it.
//
// FSM:
//   state    | meaning
//   IFB_RUN  | fetching sequentially while buffer credit allows
//   IFB_HALT | misaligned fetch PC reported; wait for a redirect
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int             DEPTH    = IFB_DEPTH_DEF,
  parameter int             AW       = IFB_AW_DEF,
  parameter int             DW       = IFB_DW_DEF,
  parameter logic [AW-1:0]  RESET_PC = AW'(IFB_RESET_PC_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          inst_sram_en,
  output logic [AW-1:0] inst_sram_addr,
  input  logic [DW-1:0] inst_sram_rdata,
  output logic          deq_valid,
  input  logic          deq_ready,
  output logic [AW-1:0] deq_pc,
  output logic [DW-1:0] deq_instr,
  output logic          deq_adel
);

  localparam int ENT_W  = ifb_ent_w(AW, DW);
  localparam int PC_LSB = IFB_INSTR_LSB + DW;
  localparam int CW     = $clog2(DEPTH + 1);

  ifb_state_e    state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] resp_pc_q, resp_pc_d;
  logic          inflight_q, inflight_d;

  logic             misaligned;
  logic             credit;
  logic             issue;
  logic             adel_take;
  logic             resp_live;
  logic             byp_hit;
  logic             deq_live;
  logic [ENT_W-1:0] resp_ent;
  logic [ENT_W-1:0] adel_ent;
  logic [ENT_W-1:0] deq_ent;

  logic             fifo_push;
  logic             fifo_pop;
  logic [ENT_W-1:0] fifo_wdata;
  logic [ENT_W-1:0] fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  // Credit, request decode, response routing and buffer control.
  always_comb begin
    misaligned = (fetch_pc_q[1:0] != 2'b00);
    // Credit counts the outstanding response so a returning word always has a slot.
    credit     = (state_q == IFB_RUN) && !redirect_valid
                 && ((int'(fifo_count) + int'(inflight_q)) < DEPTH);
    issue      = credit && !misaligned;
    // A misaligned PC only appears after a redirect, which leaves nothing in
    // flight; the inflight guard keeps the single write port unambiguous.
    adel_take  = credit && misaligned && !inflight_q;
    // A response sharing its cycle with a redirect belongs to the old path.
    resp_live  = inflight_q && !redirect_valid;
    resp_ent   = {resp_pc_q, inst_sram_rdata, 1'b0};
    adel_ent   = {fetch_pc_q, {DW{1'b0}}, 1'b1};
`ifdef IFB_BYPASS_EN
    byp_hit    = resp_live && fifo_empty;
`else
    byp_hit    = 1'b0;
`endif
    deq_ent    = fifo_empty ? resp_ent : fifo_head;
    deq_live   = !redirect_valid && (!fifo_empty || byp_hit);
    fifo_pop   = !redirect_valid && deq_ready && !fifo_empty;
    fifo_push  = (adel_take || (resp_live && !(byp_hit && deq_ready)))
                 && (!fifo_full || fifo_pop);
    fifo_wdata = adel_take ? adel_ent : resp_ent;
  end

  // FSM transitions and fetch bookkeeping next-state.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = issue;
    case (state_q)
      IFB_RUN:  if (adel_take) state_d = IFB_HALT;
      IFB_HALT: state_d = IFB_HALT;
    endcase
    if (issue) begin
      fetch_pc_d = fetch_pc_q + AW'(4);
      resp_pc_d  = fetch_pc_q;
    end
    if (redirect_valid) begin
      state_d    = IFB_RUN;
      fetch_pc_d = redirect_pc;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IFB_RUN;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
    end
  end

  inst_fetch_buffer_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (redirect_valid),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Request is held off while reset is asserted even though state is already cleared.
  assign inst_sram_en   = issue && !rst;
  assign inst_sram_addr = fetch_pc_q;

  assign deq_valid = deq_live;
  assign deq_pc    = deq_live ? deq_ent[PC_LSB +: AW] : '0;
  assign deq_instr = deq_live ? deq_ent[IFB_INSTR_LSB +: DW] : '0;
  assign deq_adel  = deq_live && deq_ent[IFB_ADEL_BIT];

endmodule
